// File: rtl/uart_tx.sv
// uart_tx: 8N1 (or 8N2) UART transmitter fed from a byte FIFO.
// Queued bytes are framed as start bit, 8 data bits LSB-first, then
// STOP_BITS stop bits, every line bit held for CLKPERBIT clocks.
// When the FIFO still has data at the end of a frame, the next start bit
// follows the last stop clock with no idle gap between frames.
//
// Write handshake: data_valid is a one-cycle write strobe with no ready
// signal. A byte is accepted at a clk edge when the FIFO is not full, or
// when the transmitter pops the head at that same edge. A byte that is not
// accepted is dropped, and overflow pulses for one cycle after that edge.
module uart_tx #(
  parameter real SYSCLOCK   = 27.0,
  parameter real BAUDRATE   = 1.0,
  parameter int  FIFO_DEPTH = 16,
  parameter int  STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       tx,
  output logic       tx_bsy,
  output logic       tx_done,
  output logic [1:0] dbg_state
);

  localparam int CLKPERBIT = int'(SYSCLOCK / BAUDRATE);
  localparam int CW        = (CLKPERBIT > 1) ? $clog2(CLKPERBIT) : 1;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int NW        = PW + 1;

  localparam logic [CW-1:0] C_LAST     = CW'(CLKPERBIT - 1);
  localparam logic [2:0]    C_STOP_END = 3'(STOP_BITS - 1);
  localparam logic [NW-1:0] C_DEPTH    = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FSM and line registers
  state_t          r_state;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_bsy;
  logic            r_ovf;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [NW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;

  // Combinational next values
  state_t          w_next_state;
  logic [CW-1:0]   w_next_cnt;
  logic [2:0]      w_next_idx;
  logic [7:0]      w_next_shift;
  logic            w_next_tx;
  logic            w_next_bsy;
  logic            w_pop;
  logic            w_done;
  logic            w_push;
  logic            w_bit_end;
  logic [NW-1:0]   w_count_next;

  assign w_bit_end = (r_clk_cnt == C_LAST);

  // A push may use the slot being freed by a pop at the same edge.
  assign w_push = data_valid && (!r_full || w_pop);

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_clk_cnt + 1'b1;
    w_next_idx   = r_bit_idx;
    w_next_shift = r_shift;
    w_next_tx    = r_tx;
    w_next_bsy   = r_bsy;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        w_next_tx  = 1'b1;
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_next_shift = r_mem[r_rd_ptr];
          w_next_state = S_START;
          w_next_tx    = 1'b0;
          w_next_bsy   = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_cnt   = '0;
          w_next_idx   = '0;
          w_next_state = S_DATA;
          w_next_tx    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_next_cnt = '0;
          if (r_bit_idx == 3'd7) begin
            w_next_idx   = '0;
            w_next_state = S_STOP;
            w_next_tx    = 1'b1;
          end else begin
            w_next_idx   = r_bit_idx + 3'd1;
            w_next_shift = {1'b0, r_shift[7:1]};
            w_next_tx    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_next_cnt = '0;
          if (r_bit_idx == C_STOP_END) begin
            w_done     = 1'b1;
            w_next_idx = '0;
            if (!r_empty) begin
              // Chain straight into the next frame's start bit.
              w_pop        = 1'b1;
              w_next_shift = r_mem[r_rd_ptr];
              w_next_state = S_START;
              w_next_tx    = 1'b0;
            end else begin
              w_next_state = S_IDLE;
              w_next_tx    = 1'b1;
              w_next_bsy   = 1'b0;
            end
          end else begin
            w_next_idx = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_tx    = 1'b1;
        w_next_bsy   = 1'b0;
      end
    endcase
  end

  // FSM state and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_bsy     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_clk_cnt <= w_next_cnt;
      r_bit_idx <= w_next_idx;
      r_shift   <= w_next_shift;
      r_tx      <= w_next_tx;
      r_bsy     <= w_next_bsy;
    end
  end

  // Occupancy after this edge's push and pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO pointers, count, registered flags and the overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_DEPTH);
      r_empty <= (w_count_next == '0);
      r_ovf   <= data_valid && !w_push;
    end
  end

  // FIFO storage; data_in is captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign overflow   = r_ovf;
  assign tx         = r_tx;
  assign tx_bsy     = r_bsy;
  assign tx_done    = w_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model (queue of bytes, position within
// a frame) predicts every output each cycle; a line receiver decodes tx and
// scores the bytes against the accepted-write queue; directed tests pin the
// model with hand-computed cycle values.
module tb_uart_tx;

  localparam int CPB   = 27;
  localparam int FLEN  = 10 * CPB;
  localparam int DEPTH = 16;

  // Clock and reset
  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // DUT with one stop bit (main) and with two stop bits
  logic [7:0] data_in, d2_in;
  logic       data_valid, d2_valid;
  logic       fifo_full, fifo_empty, overflow, tx, tx_bsy, tx_done;
  logic       f2_full, f2_empty, ovf2, tx2, bsy2, done2;
  logic [1:0] dbg_state, dbg2;

  uart_tx #(.SYSCLOCK(27.0), .BAUDRATE(1.0), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .tx(tx), .tx_bsy(tx_bsy), .tx_done(tx_done), .dbg_state(dbg_state)
  );

  uart_tx #(.SYSCLOCK(27.0), .BAUDRATE(1.0), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(d2_in), .data_valid(d2_valid),
    .fifo_full(f2_full), .fifo_empty(f2_empty), .overflow(ovf2),
    .tx(tx2), .tx_bsy(bsy2), .tx_done(done2), .dbg_state(dbg2)
  );

  // Counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: byte queue plus position within the current frame.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = '0;
  logic e_tx = 1'b1, e_bsy = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
  logic e_full = 1'b0, e_empty = 1'b1;

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos < CPB) return 1'b0;
    if (pos < 9 * CPB) return b[pos / CPB - 1];
    return 1'b1;
  endfunction

  initial begin : model
    int  sz;
    bit  pop, acc, fend;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_q.delete();
        m_active = 1'b0; m_pos = 0;
        e_tx = 1'b1; e_bsy = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
        e_full = 1'b0; e_empty = 1'b1;
      end else begin
        sz   = mq.size();
        fend = m_active && (m_pos == FLEN - 1);
        pop  = (sz > 0) && (!m_active || fend);
        acc  = data_valid && ((sz < DEPTH) || pop);
        e_ovf = data_valid && !acc;
        if (fend) begin
          if (pop) begin m_byte = mq.pop_front(); m_pos = 0; end
          else m_active = 1'b0;
        end else if (m_active) begin
          m_pos++;
        end else if (pop) begin
          m_byte = mq.pop_front(); m_pos = 0; m_active = 1'b1;
        end
        if (acc) begin
          mq.push_back(data_in);
          exp_q.push_back(data_in);
        end
        e_bsy   = m_active;
        e_done  = m_active && (m_pos == FLEN - 1);
        e_tx    = m_active ? frame_bit(m_byte, m_pos) : 1'b1;
        e_full  = (mq.size() == DEPTH);
        e_empty = (mq.size() == 0);
      end
    end
  end

  // Compare process: every output against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      check("tx", tx, e_tx);
      check("tx_bsy", tx_bsy, e_bsy);
      check("tx_done", tx_done, e_done);
      check("overflow", overflow, e_ovf);
      check("fifo_full", fifo_full, e_full);
      check("fifo_empty", fifo_empty, e_empty);
    end
  end

  // Line receiver: samples mid-bit, scores decoded bytes against exp_q.
  int rx_cnt = 0;
  initial begin : receiver
    bit         act;
    int         cnt, k;
    logic [9:0] sh;
    logic [7:0] want;
    act = 1'b0; cnt = 0; sh = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx == 1'b0) begin act = 1'b1; cnt = 0; end
      end else begin
        cnt++;
        if (cnt >= CPB / 2 && ((cnt - CPB / 2) % CPB) == 0) begin
          k = (cnt - CPB / 2) / CPB;
          sh[k] = tx;
          if (k == 9) begin
            act = 1'b0;
            rx_cnt++;
            check("rx_start_bit", sh[0], 1'b0);
            check("rx_stop_bit", sh[9], 1'b1);
            if (exp_q.size() == 0) check("rx_unexpected_byte", 1, 0);
            else begin
              want = exp_q.pop_front();
              check("rx_data", sh[8:1], want);
            end
          end
        end
      end
    end
  end

  // Driver tasks
  int t0 = 0;

  task automatic wr(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_until(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((m_active || mq.size() != 0 || tx_bsy) && g < 20000) begin
      @(posedge clk); #1;
      g++;
    end
    check("idle_within_bound", (g < 20000), 1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Directed stimulus
  initial begin : stim
    int g, rx_base;
    rst_n = 1'b0;
    data_in = '0; data_valid = 1'b0;
    d2_in = '0; d2_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_bsy", tx_bsy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single byte 0x55
    wr(8'h55); t0 = cyc;
    check("s_empty_c0", fifo_empty, 1'b0);
    wait_until(1);   check("s_tx_c1", tx, 1'b0); check("s_bsy_c1", tx_bsy, 1'b1);
                     check("s_empty_c1", fifo_empty, 1'b1);
    wait_until(27);  check("s_tx_c27", tx, 1'b0);
    wait_until(28);  check("s_tx_c28", tx, 1'b1);
    wait_until(55);  check("s_tx_c55", tx, 1'b0);
    wait_until(243); check("s_tx_c243", tx, 1'b0);
    wait_until(244); check("s_tx_c244", tx, 1'b1);
    wait_until(269); check("s_done_c269", tx_done, 1'b0);
    wait_until(270); check("s_done_c270", tx_done, 1'b1); check("s_bsy_c270", tx_bsy, 1'b1);
    wait_until(271); check("s_done_c271", tx_done, 1'b0); check("s_bsy_c271", tx_bsy, 1'b0);
                     check("s_tx_c271", tx, 1'b1);
    wait_idle();

    // Back-to-back frames
    wr(8'hA5); t0 = cyc;
    wr(8'h3C);
    wr(8'hFF);
    wait_until(28);  check("b_tx_c28", tx, 1'b1);
    wait_until(270); check("b_done_c270", tx_done, 1'b1);
    wait_until(271); check("b_tx_c271", tx, 1'b0); check("b_bsy_c271", tx_bsy, 1'b1);
    wait_until(298); check("b_tx_c298", tx, 1'b0);
    wait_until(540); check("b_done_c540", tx_done, 1'b1);
    wait_until(541); check("b_tx_c541", tx, 1'b0);
    wait_until(810); check("b_done_c810", tx_done, 1'b1);
    wait_until(811); check("b_bsy_c811", tx_bsy, 1'b0);
    wait_idle();

    // Overflow, then full + pop at the same edge
    wr(8'h10); t0 = cyc;
    for (int i = 1; i < 17; i++) wr(8'h10 + 8'(i));
    check("o_full_c16", fifo_full, 1'b1);
    check("o_ovf_c16", overflow, 1'b0);
    wr(8'hEE);
    check("o_ovf_c17", overflow, 1'b1);
    check("o_full_c17", fifo_full, 1'b1);
    wait_until(18);  check("o_ovf_c18", overflow, 1'b0);
    wait_until(270);
    wr(8'h77);
    check("fp_full_c271", fifo_full, 1'b1);
    check("fp_ovf_c271", overflow, 1'b0);
    check("fp_tx_c271", tx, 1'b0);
    wait_idle();

    // Reset during DATA bit 3 with bytes still queued
    wr(8'h0F); t0 = cyc;
    wr(8'h12);
    wr(8'h34);
    wait_until(120);
    rst_n = 1'b0;
    #1;
    check("r_tx_async", tx, 1'b1);
    check("r_bsy_async", tx_bsy, 1'b0);
    check("r_empty_async", fifo_empty, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_until(400);
    check("r_tx_after", tx, 1'b1);
    check("r_bsy_after", tx_bsy, 1'b0);
    check("r_empty_after", fifo_empty, 1'b1);
    wait_idle();

    // Loopback: 64 random bytes through the line receiver
    rx_base = rx_cnt;
    for (int i = 0; i < 64; i++) begin
      g = 0;
      while (fifo_full && g < 2000) begin @(posedge clk); #1; g++; end
      check("lb_full_wait", (g < 2000), 1);
      wr(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();
    check("lb_rx_count", rx_cnt - rx_base, 64);

    // Two stop bits: 297-clk frame on the second instance
    d2_in = 8'hC3; d2_valid = 1'b1;
    @(posedge clk); #1;
    d2_valid = 1'b0;
    t0 = cyc;
    wait_until(1);   check("d2_tx_c1", tx2, 1'b0); check("d2_bsy_c1", bsy2, 1'b1);
    wait_until(28);  check("d2_tx_c28", tx2, 1'b1);
    wait_until(82);  check("d2_tx_c82", tx2, 1'b0);
    wait_until(270); check("d2_tx_c270", tx2, 1'b1); check("d2_done_c270", done2, 1'b0);
    wait_until(296); check("d2_done_c296", done2, 1'b0);
    wait_until(297); check("d2_done_c297", done2, 1'b1);
    wait_until(298); check("d2_done_c298", done2, 1'b0); check("d2_bsy_c298", bsy2, 1'b0);
                     check("d2_tx_c298", tx2, 1'b1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
